i2s_serializer: RTL and testbench



---
 rtl/i2s_serializer.sv | 107 ++++++++++
 tb/tb_i2s_serializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// I2S master serializer fed from the playback FIFO read port.
// Define I2S_SERIALIZER_REPEAT_EN to replay the last fetched word instead of silence.
module i2s_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [63:0] playback_fifo_data,
  input  logic        playback_fifo_empty,
  output logic        playback_fifo_read,
  output logic        playback_fifo_clk,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_nxt;
  logic [63:0] shift_q;
  logic [63:0] hold_q;
  logic [63:0] load_word;
  logic        cap_pend;
  logic        div_wrap;
  logic        fall;

  assign playback_fifo_clk = clk;
  assign div_wrap = (div_cnt == DIV_LAST);
  assign fall     = div_wrap & i2s_bclk;
  assign bit_nxt  = bit_cnt + 6'd1;

`ifdef I2S_SERIALIZER_REPEAT_EN
  // hold_q keeps the last fetched word, so a missed fetch replays it
  assign load_word = {hold_q[31:0], hold_q[63:32]};
`else
  logic hold_valid;
  assign load_word = hold_valid ? {hold_q[31:0], hold_q[63:32]} : 64'h0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt            <= 8'd0;
      bit_cnt            <= 6'd63;
      shift_q            <= 64'h0;
      hold_q             <= 64'h0;
      cap_pend           <= 1'b0;
      i2s_bclk           <= 1'b1;
      i2s_lrck           <= 1'b1;
      i2s_sdata          <= 1'b0;
      playback_fifo_read <= 1'b0;
      frame_start        <= 1'b0;
      underrun           <= 1'b0;
`ifndef I2S_SERIALIZER_REPEAT_EN
      hold_valid         <= 1'b0;
`endif
    end else begin
      playback_fifo_read <= 1'b0;
      frame_start        <= 1'b0;
      underrun           <= 1'b0;
      // q is valid the cycle after the FIFO samples rdreq
      cap_pend           <= playback_fifo_read;
      if (cap_pend) begin
        hold_q <= playback_fifo_data;
`ifndef I2S_SERIALIZER_REPEAT_EN
        hold_valid <= 1'b1;
`endif
      end

      div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
      if (div_wrap)
        i2s_bclk <= ~i2s_bclk;

      if (fall) begin
        bit_cnt <= bit_nxt;
        if (bit_nxt == 6'd63)
          i2s_lrck <= 1'b0;
        else if (bit_nxt == 6'd31)
          i2s_lrck <= 1'b1;

        if (bit_nxt == 6'd0) begin
          shift_q     <= load_word;
          i2s_sdata   <= load_word[63];
          frame_start <= 1'b1;
`ifndef I2S_SERIALIZER_REPEAT_EN
          hold_valid  <= 1'b0;
`endif
        end else begin
          shift_q   <= {shift_q[62:0], 1'b0};
          i2s_sdata <= shift_q[62];
        end

        if (bit_nxt == 6'd62) begin
          if (enable && !playback_fifo_empty)
            playback_fifo_read <= 1'b1;
          else if (enable)
            underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: CLK_DIV=2 instance plus a CLK_DIV=255 instance.
// Each instance has a small normal-mode FIFO model.
module tb_i2s_serializer;

  localparam logic [63:0] W1 = 64'h8000_0001_A5A5_5A5A;
  localparam logic [63:0] E1 = 64'hA5A5_5A5A_8000_0001;
  localparam logic [63:0] W2 = 64'h1234_5678_DEAD_BEEF;
  localparam logic [63:0] E2 = 64'hDEAD_BEEF_1234_5678;
  localparam logic [63:0] W3 = 64'h0F0F_0000_FFFF_0001;
  localparam logic [63:0] E3 = 64'hFFFF_0001_0F0F_0000;
  localparam logic [63:0] W4 = 64'h5555_5555_AAAA_AAAA;

`ifdef I2S_SERIALIZER_REPEAT_EN
  localparam logic [63:0] E_AFTER2 = E2;
  localparam logic [63:0] E_AFTER3 = E3;
`else
  localparam logic [63:0] E_AFTER2 = 64'h0;
  localparam logic [63:0] E_AFTER3 = 64'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit sel = 1'b0;

  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] data_a = 64'h0;
  logic        empty_a;
  logic        read_a, fclk_a, bclk_a, lrck_a, sdata_a, fs_a, ur_a;
  logic [63:0] mem_a [8];
  int          wp_a = 0;
  int          rp_a = 0;
  int          rd_a = 0;
  int          urc_a = 0;

  logic        reset_b = 1'b0;
  logic        enable_b = 1'b1;
  logic [63:0] data_b = 64'h0;
  logic        empty_b;
  logic        read_b, fclk_b, bclk_b, lrck_b, sdata_b, fs_b, ur_b;
  logic [63:0] mem_b [8];
  int          wp_b = 0;
  int          rp_b = 0;
  int          rd_b = 0;
  int          urc_b = 0;

  i2s_serializer #(.CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .playback_fifo_data(data_a), .playback_fifo_empty(empty_a),
    .playback_fifo_read(read_a), .playback_fifo_clk(fclk_a),
    .i2s_bclk(bclk_a), .i2s_lrck(lrck_a), .i2s_sdata(sdata_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  i2s_serializer #(.CLK_DIV(255)) dut255 (
    .clk(clk), .reset_n(reset_b), .enable(enable_b),
    .playback_fifo_data(data_b), .playback_fifo_empty(empty_b),
    .playback_fifo_read(read_b), .playback_fifo_clk(fclk_b),
    .i2s_bclk(bclk_b), .i2s_lrck(lrck_b), .i2s_sdata(sdata_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  always @(posedge clk) begin
    if (read_a && wp_a != rp_a) begin
      data_a <= mem_a[rp_a % 8];
      rp_a   <= rp_a + 1;
    end
    if (read_b && wp_b != rp_b) begin
      data_b <= mem_b[rp_b % 8];
      rp_b   <= rp_b + 1;
    end
    if (read_a) rd_a <= rd_a + 1;
    if (ur_a) urc_a <= urc_a + 1;
    if (read_b) rd_b <= rd_b + 1;
    if (ur_b) urc_b <= urc_b + 1;
  end

  wire fs_m    = sel ? fs_b : fs_a;
  wire bclk_m  = sel ? bclk_b : bclk_a;
  wire sdata_m = sel ? sdata_b : sdata_a;

  task automatic push_a(input logic [63:0] w);
    mem_a[wp_a % 8] = w;
    wp_a = wp_a + 1;
  endtask

  task automatic wait_fs(output bit ok);
    int lim;
    int t;
    lim = sel ? 70000 : 2000;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (fs_m !== 1'b1 && t < lim);
    ok = (fs_m === 1'b1);
  endtask

  task automatic capture_frame(input int drop_at, output logic [63:0] w,
                               output int rds, output int urs, output bit ok);
    int r0, u0, lim;
    logic pb;
    bit got;
    w = 64'h0; rds = 0; urs = 0;
    wait_fs(ok);
    if (!ok) return;
    r0 = sel ? rd_b : rd_a;
    u0 = sel ? urc_b : urc_a;
    lim = sel ? 2000 : 20;
    pb = bclk_m;
    for (int b = 0; b < 64; b++) begin
      got = 1'b0;
      for (int t = 0; t < lim && !got; t++) begin
        @(negedge clk);
        if (bclk_m === 1'b1 && pb === 1'b0) got = 1'b1;
        pb = bclk_m;
      end
      if (!got) begin
        ok = 1'b0;
        return;
      end
      w = {w[62:0], sdata_m};
      if (b == drop_at) enable = 1'b0;
    end
    rds = (sel ? rd_b : rd_a) - r0;
    urs = (sel ? urc_b : urc_a) - u0;
    ok = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int drop_at,
                             input logic [63:0] exp_w, input int exp_rd,
                             input int exp_ur);
    logic [63:0] w;
    int rds, urs;
    bit ok;
    capture_frame(drop_at, w, rds, urs, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout waiting for frame", nm);
      return;
    end
    n_chk++;
    if (w !== exp_w) begin
      n_fail++;
      $display("FAIL %s data got %h expected %h", nm, w, exp_w);
    end
    n_chk++;
    if (rds !== exp_rd) begin
      n_fail++;
      $display("FAIL %s reads got %0d expected %0d", nm, rds, exp_rd);
    end
    n_chk++;
    if (urs !== exp_ur) begin
      n_fail++;
      $display("FAIL %s underruns got %0d expected %0d", nm, urs, exp_ur);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    logic [5:0] got;
    got = {bclk_a, lrck_a, sdata_a, read_a, fs_a, ur_a};
    n_chk++;
    if (got !== 6'b110000) begin
      n_fail++;
      $display("FAIL %s bclk/lrck/sdata/read/fs/ur got %b expected 110000",
               nm, got);
    end
  endtask

  // Watches a fresh run with enable low and measures the framing.
  task automatic test_timing_window(input string nm, input bit full);
    int c, bf0, bf1, lf0, lf1, fsd, r0;
    bit sd_hi;
    logic pb, pl;
    bf0 = -1; bf1 = -1; lf0 = -1; lf1 = -1; fsd = -1;
    sd_hi = 1'b0;
    r0 = rd_a;
    pb = bclk_a; pl = lrck_a;
    for (c = 0; c < 700; c++) begin
      @(negedge clk);
      if (pb === 1'b1 && bclk_a === 1'b0) begin
        if (bf0 < 0) bf0 = c;
        else if (bf1 < 0) bf1 = c;
      end
      if (pl === 1'b1 && lrck_a === 1'b0) begin
        if (lf0 < 0) lf0 = c;
        else if (lf1 < 0) lf1 = c;
      end
      if (fs_a === 1'b1 && lf0 >= 0 && fsd < 0) fsd = c - lf0;
      if (sdata_a !== 1'b0) sd_hi = 1'b1;
      pb = bclk_a; pl = lrck_a;
    end
    n_chk++;
    if (fsd !== 4) begin
      n_fail++;
      $display("FAIL %s lrck_fall_to_frame_start got %0d expected 4", nm, fsd);
    end
    n_chk++;
    if (rd_a - r0 !== 0) begin
      n_fail++;
      $display("FAIL %s reads got %0d expected 0", nm, rd_a - r0);
    end
    if (full) begin
      n_chk++;
      if (bf1 - bf0 !== 4) begin
        n_fail++;
        $display("FAIL %s bclk_period got %0d expected 4", nm, bf1 - bf0);
      end
      n_chk++;
      if (lf1 - lf0 !== 256) begin
        n_fail++;
        $display("FAIL %s lrck_period got %0d expected 256", nm, lf1 - lf0);
      end
      n_chk++;
      if (sd_hi !== 1'b0) begin
        n_fail++;
        $display("FAIL %s sdata_idle got 1 expected 0", nm);
      end
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
  endtask

  task automatic test_bclk_lrck;
    reset_n = 1'b1;
    test_timing_window("timing", 1'b1);
  endtask

  task automatic test_serialization;
    bit ok;
    wait_fs(ok);
    enable = 1'b1;
    push_a(W1);
    push_a(W2);
    check_frame("serial_w1", -1, E1, 1, 0);
  endtask

  task automatic test_underrun;
    check_frame("underrun_w2", -1, E2, 0, 1);
    check_frame("underrun_f3", -1, E_AFTER2, 0, 1);
  endtask

  task automatic test_enable_mid;
    push_a(W3);
    push_a(W4);
    check_frame("enable_pre", -1, E_AFTER2, 1, 0);
    check_frame("enable_drop", 10, E3, 0, 0);
    check_frame("enable_off", -1, E_AFTER3, 0, 0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit got;
    logic pb;
    int rises;
    wait_fs(ok);
    rises = 0;
    pb = bclk_a;
    for (int t = 0; t < 400 && rises < 40; t++) begin
      @(negedge clk);
      if (bclk_a === 1'b1 && pb === 1'b0) rises++;
      pb = bclk_a;
    end
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bclk_a === 1'b0) got = 1'b1;
    end
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    wp_a = rp_a;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_timing_window("reset_release", 1'b0);
  endtask

  task automatic test_divider_extremes;
    bit ok;
    mem_b[0] = W1;
    wp_b = 1;
    sel = 1'b1;
    @(negedge clk);
    reset_b = 1'b1;
    wait_fs(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL div255_first_frame timeout");
    end
    check_frame("div255_w1", -1, E1, 0, 1);
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_bclk_lrck;
    test_serialization;
    test_underrun;
    test_enable_mid;
    test_reset_mid;
    test_divider_extremes;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
